alu_serial_seq: RTL and testbench



---
 rtl/alu_serial_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_serial_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives one 1-bit ALU slice per clock, LSB first, and assembles result + flags.
// Optional ALU_SERIAL_OVF_EN: enables signed overflow tracking and an overflow-correct SLT.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request sampled only while IDLE; busy covers accept..FIN,
    // done is a one-cycle pulse after FIN, and a start seen while busy is dropped.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             msb_sum_q, msb_sum_d;
    logic             cout_msb_q, cout_msb_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
`ifdef ALU_SERIAL_OVF_EN
    logic             cin_msb_q, cin_msb_d;
    logic             overflow_q, overflow_d;
    logic             ovf_fin;
`endif

    logic             a_bit, b_bit, sum_bit, slice_cout, slice_res;
    logic             op_valid, is_arith, is_slt, slt_bit;
    logic [WIDTH-1:0] final_res;

    // Opcode fields: [3] A_invert, [2] B_invert, [1:0] slice mux (AND/OR/SUM/LESS).
    always_comb begin
        op_valid = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ADD) ||
                   (op_q == OP_SUB) || (op_q == OP_NOR) || (op_q == OP_SLT);
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
        is_slt   = (op_q == OP_SLT);

        a_bit      = a_q[cnt_q] ^ op_q[3];
        b_bit      = b_q[cnt_q] ^ op_q[2];
        sum_bit    = a_bit ^ b_bit ^ carry_q;
        slice_cout = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
        case (op_q[1:0])
            2'b00:   slice_res = a_bit & b_bit;
            2'b01:   slice_res = a_bit | b_bit;
            2'b10:   slice_res = sum_bit;
            default: slice_res = 1'b0;  // less input is held at 0 while running
        endcase
    end

    always_comb begin
`ifdef ALU_SERIAL_OVF_EN
        ovf_fin = is_arith & (cin_msb_q ^ cout_msb_q);
        slt_bit = msb_sum_q ^ ovf_fin;
`else
        slt_bit = msb_sum_q;
`endif
        if (!op_valid)
            final_res = '0;
        else if (is_slt)
            final_res = {{(WIDTH-1){1'b0}}, slt_bit};
        else
            final_res = work_q;
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        msb_sum_d  = msb_sum_q;
        cout_msb_d = cout_msb_q;
        done_d     = 1'b0;
        result_d   = result_q;
        zero_d     = zero_q;
        cout_d     = cout_q;
`ifdef ALU_SERIAL_OVF_EN
        cin_msb_d  = cin_msb_q;
        overflow_d = overflow_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = ALU_control;
                    work_d  = '0;
                    cnt_d   = '0;
                    carry_d = (ALU_control == OP_SUB) || (ALU_control == OP_SLT);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d[cnt_q] = slice_res;
                carry_d       = slice_cout;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    msb_sum_d  = sum_bit;
                    cout_msb_d = slice_cout;
`ifdef ALU_SERIAL_OVF_EN
                    cin_msb_d  = carry_q;
`endif
                    cnt_d      = '0;
                    state_d    = S_FIN;
                end
            end
            S_FIN: begin
                result_d   = final_res;
                zero_d     = op_valid && (final_res == '0);
                cout_d     = is_arith & cout_msb_q;
`ifdef ALU_SERIAL_OVF_EN
                overflow_d = ovf_fin;
`endif
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            msb_sum_q  <= 1'b0;
            cout_msb_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            cin_msb_q  <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            msb_sum_q  <= msb_sum_d;
            cout_msb_q <= cout_msb_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            cout_q     <= cout_d;
`ifdef ALU_SERIAL_OVF_EN
            cin_msb_q  <= cin_msb_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;
`ifdef ALU_SERIAL_OVF_EN
    assign overflow  = overflow_q;
`else
    assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed + randomized bench for alu_serial_seq against a plain-arithmetic reference model.
module tb_alu_serial_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] src1, src2;
    logic [3:0]       alu_control;
    logic             busy, done, zero, cout, overflow;
    logic [WIDTH-1:0] result;
    logic [1:0]       dbg_state;

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .src1(src1), .src2(src2),
        .ALU_control(alu_control), .busy(busy), .done(done), .result(result),
        .zero(zero), .cout(cout), .overflow(overflow), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model from the opcode table using ordinary integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  output logic [31:0] r, output logic z, output logic c, output logic v);
        logic [32:0] s;
        logic        valid;
        r = '0; z = 1'b0; c = 1'b0; v = 1'b0; valid = 1'b1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0110, 4'b0111: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                c = s[32];
                v = (a[31] != b[31]) && (s[31] != a[31]);
                if (op == 4'b0110)
                    r = s[31:0];
                else begin
`ifdef ALU_SERIAL_OVF_EN
                    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
                    r = {31'd0, s[31]};
`endif
                end
            end
            default: valid = 1'b0;
        endcase
        if (valid) z = (r == 32'd0);
`ifndef ALU_SERIAL_OVF_EN
        v = 1'b0;
`endif
    endfunction

    // driver tasks
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < WIDTH + 8; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic check_outputs(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input string tag);
        logic [31:0] r, exp_r;
        logic z, c, v;
        model(a, b, op, r, z, c, v);
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : ~r;
        check({tag, ".result"},   result,              exp_r);
        check({tag, ".zero"},     {31'd0, zero},       {31'd0, z});
        check({tag, ".cout"},     {31'd0, cout},       {31'd0, c});
        check({tag, ".overflow"}, {31'd0, overflow},   {31'd0, v});
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        logic z, c, v;
        model(a, b, op, r, z, c, v);
        exp_q.push_back(r);
        src1 = a; src2 = b; alu_control = op; start = 1'b1;
    endtask

    task automatic scramble_inputs();
        src1 = $urandom; src2 = $urandom; alu_control = 4'($urandom_range(0, 15));
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input string tag);
        int cyc;
        issue(a, b, op);
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check({tag, ".latency"}, cyc, WIDTH + 1);
        check_outputs(a, b, op, tag);
    endtask

    logic [3:0] op_tab [8];

    initial begin
        int cyc;
        logic seen_done;
        logic [31:0] ra, rb;
        op_tab[0] = 4'b0000; op_tab[1] = 4'b0001; op_tab[2] = 4'b0010; op_tab[3] = 4'b0110;
        op_tab[4] = 4'b1100; op_tab[5] = 4'b0111; op_tab[6] = 4'b0100; op_tab[7] = 4'b1111;

        rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; alu_control = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.busy",     {31'd0, busy},     32'd0);
        check("reset.done",     {31'd0, done},     32'd0);
        check("reset.result",   result,            32'd0);
        check("reset.flags",    {29'd0, zero, cout, overflow}, 32'd0);

        do_op(32'd5, 32'd3, 4'b0010, "add_5_3");
        do_op(32'd3, 32'd5, 4'b0110, "sub_3_5");
        do_op(32'd5, 32'd5, 4'b0110, "sub_5_5");
        do_op(32'h7FFF_FFFF, 32'd1, 4'b0010, "add_ovf");
        do_op(32'h8000_0000, 32'd1, 4'b0111, "slt_min_1");
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0111, "slt_max_m1");
        do_op(32'd0, 32'd0, 4'b1100, "nor_0_0");
        do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, "and_pat");
        do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, "or_pat");
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b1111, "bad_op");
        do_op(32'h8000_0000, 32'h8000_0000, 4'b0010, "add_neg_ovf");

        // start pulsed during RUN cycle 5 must be ignored
        issue(32'd100, 32'd23, 4'b0010);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        src1 = 32'hDEAD_BEEF; src2 = 32'h1111_1111; alu_control = 4'b0110; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        check("ignore_start.latency", cyc + 5, WIDTH + 1);
        check_outputs(32'd100, 32'd23, 4'b0010, "ignore_start");
        @(posedge clk); #1;
        check("ignore_start.idle", {30'd0, busy, done}, 32'd0);

        // start held high through done: second op accepted on the edge after FIN
        issue(32'd7, 32'd9, 4'b0110);
        @(posedge clk); #1;
        src1 = 32'd40; src2 = 32'd2; alu_control = 4'b0010;
        wait_done(cyc);
        check("b2b_first.latency", cyc, WIDTH + 1);
        check_outputs(32'd7, 32'd9, 4'b0110, "b2b_first");
        exp_q.push_back(32'd42);
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        check("b2b_second.busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check("b2b_second.latency", cyc, WIDTH + 1);
        check_outputs(32'd40, 32'd2, 4'b0010, "b2b_second");

        // reset mid-run discards the operation
        do_op(32'h1234, 32'd1, 4'b0010, "pre_rst");
        issue(32'd9, 32'd9, 4'b0010);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid.busy",   {31'd0, busy}, 32'd0);
        check("rst_mid.result", result,        32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("rst_mid.no_done", {31'd0, seen_done}, 32'd0);
        do_op(32'd1, 32'd1, 4'b0010, "post_rst_add");

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? ra : $urandom;
            do_op(ra, rb, op_tab[$urandom_range(0, 7)], $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
